prewish_debounce_array: RTL and testbench

PREWISH_DEBOUNCE_ARRAY -- requirements
Module: prewish_debounce_array

---
 rtl/prewish_debounce_array.sv | 137 +++++++++++++
 tb/tb_prewish_debounce_array.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/prewish_debounce_array.sv
`default_nettype none
// ============================================================================
// Module      : prewish_debounce_array
// Description : Per-channel synchroniser + hold-off debouncer with a
//               strobe/ack status read port. Define PREWISH_DBNC_EDGE_EN to
//               report sticky rising-edge flags instead of debounced levels.
// Revision    : 1.0 - initial release
// ============================================================================
module prewish_debounce_array #(
    parameter int NUM_CH      = 8,
    parameter int TIME_PERIOD = 100000,
    parameter int TIME_BITS   = 17
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              STB_I,
    input  logic [7:0]        DAT_I,
    input  logic [NUM_CH-1:0] i_buttons,
    output logic              STB_O,
    output logic [7:0]        DAT_O,
    output logic              o_alive
);

    localparam logic [TIME_BITS-1:0] c_reload = TIME_BITS'(TIME_PERIOD - 1);
    localparam logic [TIME_BITS-1:0] c_one    = TIME_BITS'(1);

    localparam logic [1:0] c_idle = 2'b00;
    localparam logic [1:0] c_arm  = 2'b01;
    localparam logic [1:0] c_ack  = 2'b11;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              w_stb_next;
    logic              w_capture;
    logic [NUM_CH-1:0] w_status;
    logic [7:0]        w_status_ext;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic                 r_sync1;
        logic                 r_sync2;
        logic                 r_deb;
        logic [TIME_BITS-1:0] r_timer;
        logic                 w_tmr_zero;

        assign w_tmr_zero = (r_timer == '0);

        always_ff @(posedge CLK_I or negedge RST_I) begin
            if (!RST_I) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_deb   <= 1'b0;
                r_timer <= '0;
            end else begin
                r_sync1 <= i_buttons[gi];
                r_sync2 <= r_sync1;
                // A debounced change and the hold-off reload happen on the same edge
                if (!w_tmr_zero) begin
                    r_timer <= r_timer - c_one;
                end else if (r_sync2 != r_deb) begin
                    r_timer <= c_reload;
                end
                if (w_tmr_zero) begin
                    r_deb <= r_sync2;
                end
            end
        end

`ifdef PREWISH_DBNC_EDGE_EN
        logic r_flag;
        logic w_rise;

        assign w_rise = w_tmr_zero & r_sync2 & ~r_deb;

        // A rise coinciding with the clearing capture wins, so no edge is lost
        always_ff @(posedge CLK_I or negedge RST_I) begin
            if (!RST_I) begin
                r_flag <= 1'b0;
            end else begin
                r_flag <= w_rise | (r_flag & ~(w_capture & DAT_I[gi]));
            end
        end

        assign w_status[gi] = r_flag;
`else
        assign w_status[gi] = r_deb;
`endif
    end

    always_comb begin
        w_status_ext               = '0;
        w_status_ext[NUM_CH-1:0]   = w_status;
    end

    always_comb begin
        w_state_next = r_state;
        w_stb_next   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            c_idle: begin
                if (STB_I) begin
                    w_capture    = 1'b1;
                    w_state_next = c_arm;
                end
            end
            c_arm: begin
                if (!STB_I) begin
                    w_stb_next   = 1'b1;
                    w_state_next = c_ack;
                end
            end
            c_ack: begin
                w_state_next = c_idle;
            end
            default: begin
                w_state_next = c_idle;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state <= c_idle;
            STB_O   <= 1'b0;
            DAT_O   <= 8'h00;
            o_alive <= 1'b1;
        end else begin
            r_state <= w_state_next;
            STB_O   <= w_stb_next;
            if (w_capture) begin
                DAT_O   <= w_status_ext & DAT_I;
                o_alive <= ~o_alive;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prewish_debounce_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_prewish_debounce_array
// Description : Directed self-checking bench for prewish_debounce_array
//               (NUM_CH=4, TIME_PERIOD=37, TIME_BITS=6).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prewish_debounce_array;

    localparam int c_num_ch = 4;

    logic                clk       = 1'b0;
    logic                clk_en    = 1'b0;
    logic                rst_n     = 1'b1;
    logic                stb_i     = 1'b0;
    logic [7:0]          dat_i     = 8'h00;
    logic [c_num_ch-1:0] buttons   = '0;
    logic                stb_o;
    logic [7:0]          dat_o;
    logic                alive;

    int   n_cmp     = 0;
    int   n_err     = 0;
    logic exp_alive = 1'b1;

    prewish_debounce_array #(
        .NUM_CH      (c_num_ch),
        .TIME_PERIOD (37),
        .TIME_BITS   (6)
    ) dut (
        .CLK_I     (clk),
        .RST_I     (rst_n),
        .STB_I     (stb_i),
        .DAT_I     (dat_i),
        .i_buttons (buttons),
        .STB_O     (stb_o),
        .DAT_O     (dat_o),
        .o_alive   (alive)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Full request: STB_I high for 'hold' cycles, then low; pulse one edge later
    task automatic do_request(input string tag, input int hold,
                              input logic [7:0] mask, input logic [7:0] exp_dat);
        dat_i = mask;
        stb_i = 1'b1;
        repeat (hold) tick();
        check({tag, "_stb_hold"}, {7'b0, stb_o}, 8'h00);
        stb_i = 1'b0;
        tick();
        exp_alive = ~exp_alive;
        check({tag, "_stb_pulse"}, {7'b0, stb_o}, 8'h01);
        check({tag, "_dat"}, dat_o, exp_dat);
        check({tag, "_alive"}, {7'b0, alive}, {7'b0, exp_alive});
        tick();
        check({tag, "_stb_end"}, {7'b0, stb_o}, 8'h00);
    endtask

    initial begin
        // Asynchronous reset with no clock running
        #1 rst_n = 1'b0;
        #2;
        check("rst_stb", {7'b0, stb_o}, 8'h00);
        check("rst_dat", dat_o, 8'h00);
        check("rst_alive", {7'b0, alive}, 8'h01);
        clk_en = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

`ifdef PREWISH_DBNC_EDGE_EN
        buttons = 4'b0100;
        repeat (60) tick();
        buttons = 4'b0000;
        repeat (50) tick();
        do_request("edge_rd1", 1, 8'hFF, 8'h04);
        do_request("edge_rd2", 1, 8'hFF, 8'h00);
        buttons = 4'b0010;
        repeat (5) tick();
        buttons = 4'b0000;
        repeat (45) tick();
        do_request("edge_masked", 1, 8'h00, 8'h00);
        do_request("edge_kept", 1, 8'hFF, 8'h02);
`else
        // Capture on the same edge as the debounced update sees the old level
        buttons = 4'b0010;
        repeat (2) tick();
        do_request("early", 1, 8'hFF, 8'h00);
        do_request("late", 1, 8'hFF, 8'h02);
        buttons = 4'b0000;
        repeat (80) tick();

        buttons = 4'b0101;
        repeat (3) tick();
        do_request("level", 2, 8'hFF, 8'h05);
        buttons = 4'b1010;
        repeat (5) tick();
        check("dat_hold", dat_o, 8'h05);

        buttons = 4'b1111;
        repeat (3) tick();
        do_request("mask", 1, 8'hF6, 8'h06);
        do_request("held_high", 9, 8'hFF, 8'h0F);

        buttons = 4'b0000;
        repeat (80) tick();
        do_request("settled_low", 1, 8'hFF, 8'h00);

        // ch0 bounces every 5 cycles; the first rise opens a 36-cycle hold-off
        for (int i = 0; i < 30; i++) begin
            buttons[0] = ((i / 5) % 2 == 0);
            tick();
        end
        buttons = 4'b0001;
        do_request("bounce_mid", 1, 8'h01, 8'h01);
        repeat (50) tick();
        do_request("bounce_final", 1, 8'h01, 8'h01);
        do_request("bounce_all", 1, 8'hFF, 8'h01);

        // Reset while waiting in ARM aborts the request
        dat_i = 8'hFF;
        stb_i = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        exp_alive = 1'b1;
        check("abort_stb", {7'b0, stb_o}, 8'h00);
        check("abort_dat", dat_o, 8'h00);
        check("abort_alive", {7'b0, alive}, 8'h01);
        stb_i = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("abort_no_pulse1", {7'b0, stb_o}, 8'h00);
        tick();
        check("abort_no_pulse2", {7'b0, stb_o}, 8'h00);
        repeat (2) tick();
        do_request("after_abort", 1, 8'hFF, 8'h01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
